// File: rtl/mult_bcd_converter.sv
// Signed 16-bit product to sign + 5-digit BCD converter (16-step double-dabble).
// Optional leading-zero blanking is enabled by defining MULT_BCD_LEADING_ZERO_BLANK_EN.
module mult_bcd_converter (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   input  logic [15:0] mult_in,
   output logic        busy,
   output logic        done,
   output logic        sign,
   output logic [19:0] bcd,
   output logic [4:0]  digit_blank
);

   typedef enum logic {IDLE, CONVERT} state_t;

   state_t      state_q, state_d;
   logic [15:0] mag_q, mag_d;
   logic [18:0] work_q, work_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        neg_q, neg_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        sign_q, sign_d;
   logic [19:0] bcd_q, bcd_d;
   logic [15:0] adj_lo;
   logic [19:0] step;

   // Before any step the working value is at most 16384, so digit 4 never needs
   // the add-3 correction and bit 19 of the working register is always zero.
   always_comb begin
      adj_lo = work_q[15:0];
      for (int unsigned i = 0; i < 4; i++) begin
         if (work_q[4*i +: 4] >= 4'd5)
            adj_lo[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
      step = {work_q[18:16], adj_lo, mag_q[15]};
   end

   always_comb begin
      state_d = state_q;
      mag_d   = mag_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      sign_d  = sign_q;
      bcd_d   = bcd_q;
      case (state_q)
         IDLE: begin
            if (valid) begin
               state_d = CONVERT;
               busy_d  = 1'b1;
               cnt_d   = '0;
               work_d  = '0;
               neg_d   = mult_in[15];
               mag_d   = mult_in[15] ? (~mult_in + 16'd1) : mult_in;
            end
         end
         CONVERT: begin
            work_d = step[18:0];
            mag_d  = {mag_q[14:0], 1'b0};
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               bcd_d   = step;
               sign_d  = neg_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         mag_q   <= '0;
         work_q  <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sign_q  <= 1'b0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         mag_q   <= mag_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sign_q  <= sign_d;
         bcd_q   <= bcd_d;
      end
   end

`ifdef MULT_BCD_LEADING_ZERO_BLANK_EN
   logic [4:0] blank_q, blank_d;

   // Blank each digit above the most significant non-zero one; units always shown.
   always_comb begin
      blank_d = blank_q;
      if (state_q == CONVERT && cnt_q == 4'd15) begin
         blank_d[4] = (step[19:16] == 4'd0);
         blank_d[3] = blank_d[4] && (step[15:12] == 4'd0);
         blank_d[2] = blank_d[3] && (step[11:8] == 4'd0);
         blank_d[1] = blank_d[2] && (step[7:4] == 4'd0);
         blank_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         blank_q <= 5'b11110;
      else
         blank_q <= blank_d;
   end

   assign digit_blank = blank_q;
`else
   assign digit_blank = '0;
`endif

   assign busy = busy_q;
   assign done = done_q;
   assign sign = sign_q;
   assign bcd  = bcd_q;

endmodule

// File: tb/tb_mult_bcd_converter.sv
// Self-checking bench for mult_bcd_converter: directed vector table plus
// hand-written sequences for ignore-while-busy, mid-conversion reset and back-to-back.
module tb_mult_bcd_converter;

   logic        clk;
   logic        reset;
   logic        valid;
   logic [15:0] mult_in;
   logic        busy;
   logic        done;
   logic        sign;
   logic [19:0] bcd;
   logic [4:0]  digit_blank;

   int n_checks = 0;
   int n_fail   = 0;

   logic [19:0] prev_bcd;
   logic        prev_sign;

   typedef struct {
      logic [15:0] in;
      logic        exp_sign;
      logic [19:0] exp_bcd;
      logic [4:0]  exp_blank_on;
   } vec_t;

   vec_t vecs[15];

   mult_bcd_converter dut (
      .clk         (clk),
      .reset       (reset),
      .valid       (valid),
      .mult_in     (mult_in),
      .busy        (busy),
      .done        (done),
      .sign        (sign),
      .bcd         (bcd),
      .digit_blank (digit_blank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] blank_exp(input logic [4:0] on_val);
`ifdef MULT_BCD_LEADING_ZERO_BLANK_EN
      return on_val;
`else
      return 5'b00000;
`endif
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Capture v, then wait for done; returns sample index of done and busy-high count.
   task automatic run_conv(input logic [15:0] v, output int lat, output int bcnt);
      @(negedge clk);
      valid   = 1'b1;
      mult_in = v;
      @(posedge clk);
      #1;
      valid   = 1'b0;
      mult_in = '0;
      lat  = 0;
      bcnt = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (done) begin
            lat = n;
            break;
         end
         if (busy) bcnt++;
         if (n == 8) begin
            chk("hold_bcd", {12'd0, bcd}, {12'd0, prev_bcd});
            chk("hold_sign", {31'd0, sign}, {31'd0, prev_sign});
         end
      end
   endtask

   initial begin
      int lat, bcnt, ndone, d1, d2;
      logic [19:0] got_bcd;
      logic        got_sign;
      logic [4:0]  got_blank;

      vecs[0]  = '{16'h0000, 1'b0, 20'h00000, 5'b11110};
      vecs[1]  = '{16'hC080, 1'b1, 20'h16256, 5'b00000};
      vecs[2]  = '{16'h4000, 1'b0, 20'h16384, 5'b00000};
      vecs[3]  = '{16'h8000, 1'b1, 20'h32768, 5'b00000};
      vecs[4]  = '{16'h002A, 1'b0, 20'h00042, 5'b11100};
      vecs[5]  = '{16'h0063, 1'b0, 20'h00099, 5'b11100};
      vecs[6]  = '{16'h0005, 1'b0, 20'h00005, 5'b11110};
      vecs[7]  = '{16'hFFFB, 1'b1, 20'h00005, 5'b11110};
      vecs[8]  = '{16'h7FFF, 1'b0, 20'h32767, 5'b00000};
      vecs[9]  = '{16'hFFFF, 1'b1, 20'h00001, 5'b11110};
      vecs[10] = '{16'h03E8, 1'b0, 20'h01000, 5'b11000};
      vecs[11] = '{16'h2710, 1'b0, 20'h10000, 5'b00000};
      vecs[12] = '{16'h000A, 1'b0, 20'h00010, 5'b11100};
      vecs[13] = '{16'hFC18, 1'b1, 20'h01000, 5'b11000};
      vecs[14] = '{16'h8001, 1'b1, 20'h32767, 5'b00000};

      reset   = 1'b0;
      valid   = 1'b0;
      mult_in = '0;
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_sign", {31'd0, sign}, 32'd0);
      chk("rst_bcd", {12'd0, bcd}, 32'd0);
      chk("rst_blank", {27'd0, digit_blank}, {27'd0, blank_exp(5'b11110)});
      repeat (2) @(negedge clk);
      reset = 1'b1;
      prev_bcd  = '0;
      prev_sign = 1'b0;

      for (int i = 0; i < 15; i++) begin
         run_conv(vecs[i].in, lat, bcnt);
         chk($sformatf("latency[%0d]", i), lat, 32'd17);
         chk($sformatf("busy_cycles[%0d]", i), bcnt, 32'd16);
         chk($sformatf("busy_at_done[%0d]", i), {31'd0, busy}, 32'd0);
         chk($sformatf("sign[%0d]", i), {31'd0, sign}, {31'd0, vecs[i].exp_sign});
         chk($sformatf("bcd[%0d]", i), {12'd0, bcd}, {12'd0, vecs[i].exp_bcd});
         chk($sformatf("blank[%0d]", i), {27'd0, digit_blank},
             {27'd0, blank_exp(vecs[i].exp_blank_on)});
         @(negedge clk);
         chk($sformatf("done_width[%0d]", i), {31'd0, done}, 32'd0);
         prev_bcd  = vecs[i].exp_bcd;
         prev_sign = vecs[i].exp_sign;
      end

      // valid during CONVERT must be ignored
      @(negedge clk);
      valid   = 1'b1;
      mult_in = 16'h002A;
      @(posedge clk);
      #1;
      valid = 1'b0;
      ndone = 0;
      got_bcd = '0; got_sign = 1'b0; got_blank = '0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 5) begin
            valid   = 1'b1;
            mult_in = 16'h0001;
         end else if (n == 6) begin
            valid   = 1'b0;
            mult_in = '0;
         end
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               got_bcd = bcd; got_sign = sign; got_blank = digit_blank;
            end
         end
      end
      chk("ign_done_count", ndone, 32'd1);
      chk("ign_bcd", {12'd0, got_bcd}, 32'h00042);
      chk("ign_sign", {31'd0, got_sign}, 32'd0);
      chk("ign_blank", {27'd0, got_blank}, {27'd0, blank_exp(5'b11100)});

      // reset asserted mid-conversion aborts without done
      @(negedge clk);
      valid   = 1'b1;
      mult_in = 16'h0063;
      @(posedge clk);
      #1;
      valid = 1'b0;
      repeat (8) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk("mid_rst_sign", {31'd0, sign}, 32'd0);
      chk("mid_rst_bcd", {12'd0, bcd}, 32'd0);
      chk("mid_rst_blank", {27'd0, digit_blank}, {27'd0, blank_exp(5'b11110)});
      @(negedge clk);
      reset = 1'b1;
      ndone = 0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      chk("mid_rst_no_done", ndone, 32'd0);
      prev_bcd  = '0;
      prev_sign = 1'b0;
      run_conv(16'h0063, lat, bcnt);
      chk("post_rst_latency", lat, 32'd17);
      chk("post_rst_bcd", {12'd0, bcd}, 32'h00099);

      // back-to-back with valid held through the done cycle
      @(negedge clk);
      valid   = 1'b1;
      mult_in = 16'h0005;
      @(posedge clk);
      #1;
      mult_in = 16'hFFFB;
      d1 = 0;
      d2 = 0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (done) begin
            if (d1 == 0) begin
               d1 = n;
               chk("b2b_sign0", {31'd0, sign}, 32'd0);
               chk("b2b_bcd0", {12'd0, bcd}, 32'h00005);
            end else if (d2 == 0) begin
               d2 = n;
               chk("b2b_sign1", {31'd0, sign}, 32'd1);
               chk("b2b_bcd1", {12'd0, bcd}, 32'h00005);
            end
         end
         if (d1 != 0 && n == d1 + 1) valid = 1'b0;
      end
      chk("b2b_first_latency", d1, 32'd17);
      chk("b2b_spacing", d2 - d1, 32'd17);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mult_bcd_converter.md
# mult_bcd_converter

Sequential signed-binary to BCD converter that sits directly downstream of the Booth multiplier top. It captures the 16-bit signed product when the multiplier signals ready. It then converts the magnitude to five BCD digits using a 16-iteration shift-add-3 (double-dabble) sequence, and presents sign plus digits to the display stage. Outputs are registered and held until the next conversion completes.

## Interface

Parameters: none. Widths are fixed: 16-bit input, 5 BCD digits.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- valid  input  1  product available; driven from multiplier `mult_ready`
- mult_in  input  16  signed two's-complement product from multiplier `mult`
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when new `sign`/`bcd` are valid
- sign  output  1  1 = captured product was negative
- bcd  output  20  magnitude digits; [19:16] ten-thousands … [3:0] units
- digit_blank  output  5  per-digit leading-zero blank mask, bit i ↔ bcd[4i+3:4i]

## Operation

- States: IDLE, CONVERT.
- IDLE, valid=1: capture `mult_in`, go to CONVERT, busy=1, iteration counter=0.
  - Capture computes sign = mult_in[15].
  - Magnitude is computed as a 16-bit unsigned value: two's-complement negate if negative, else pass through. -32768 → magnitude 32768.
- CONVERT: each cycle performs one double-dabble step on a 20-bit working BCD register.
  - Step: add 3 to every digit ≥5, then shift left 1, bringing in the magnitude MSB.
  - After the 16th step: load `bcd` and `sign` output registers, pulse done=1 for one cycle, busy=0, return to IDLE.
- valid while in CONVERT is ignored. The input is not queued and the running conversion is unaffected.
- `bcd`, `sign` and `digit_blank` change only on the completion edge. Between conversions they hold their last values.
- Every digit of `bcd` is 0–9 at all times.
- Maximum magnitude is 32768, so digit 4 ≤ 3.
- Zero result: sign=0, bcd=0.

## Timing

- Reset (asynchronous assert, synchronous release) sets:
  - state=IDLE, busy=0, done=0, sign=0, bcd=20'h00000.
  - digit_blank = 5'b11110 with the macro defined, 5'b00000 without.
- Capture edge = edge T.
  - busy is high from after T through the cycle ending at edge T+16.
  - Outputs update at edge T+16; done is high for exactly the cycle after T+16.
- Latency: 16 cycles from capture edge to done. Throughput: one conversion per 17 cycles.
- A valid in the done-high cycle is accepted (state is IDLE). Back-to-back conversions are therefore possible.
- Reset mid-CONVERT aborts immediately to the reset values. No done pulse is produced, and the partial result is discarded.

## Configuration

- Macro `MULT_BCD_LEADING_ZERO_BLANK_EN`.
- Defined: on completion, digit_blank[i]=1 for every digit above the most significant non-zero digit. digit_blank[0] is always 0, so the units digit is always shown. Examples:
  - 42 → 5'b11100
  - 0 → 5'b11110
  - 16384 → 5'b00000
- Undefined: digit_blank tied to 5'b00000; no blank logic synthesised.

## Test plan

- Reset, then valid with mult_in=16'h0000 → done 16 cycles after capture; sign=0, bcd=20'h00000; digit_blank=5'b11110 (macro on).
- mult_in=16'hC080 (-16256, from -128×127) → sign=1, bcd=20'h16256; busy high for exactly 16 cycles; done one cycle wide.
- mult_in=16'h4000 (16384, from -128×-128) → sign=0, bcd=20'h16384, digit_blank=5'b00000. Then mult_in=16'h8000 → sign=1, bcd=20'h32768.
- mult_in=16'h002A (42); drive valid with mult_in=16'h0001 at cycle 5 of conversion → result still bcd=20'h00042, digit_blank=5'b11100 (macro on; 5'b00000 macro off); only one done pulse.
- Start conversion of 16'h0063, then assert reset at cycle 8 → outputs return to reset values, no done. After release, converting 16'h0063 yields bcd=20'h00099.
- Back-to-back: valid held high through done cycle with 16'h0005 then 16'hFFFB → two done pulses 17 cycles apart; results 00005/sign 0, then 00005/sign 1.
